// File: rtl/hyperbus_pkg.sv
// Shared HyperBus types: PHY RX word layout and RX packer FSM states.
package hyperbus_pkg;

  localparam int unsigned HyperNumPhys  = 2;
  localparam int unsigned HyperPhyWidth = 16 * HyperNumPhys;

  typedef struct packed {
    logic [HyperPhyWidth-1:0] data;
    logic                     last;
    logic                     error;
  } hyper_rx_t;

  typedef enum logic {
    IDLE,
    PACK
  } rx_pack_state_e;

  function automatic int unsigned lane_idx_w(
    input int unsigned ratio
  );
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/hyperbus_rx_packer_if.sv
// Command, PHY-word and packed-word handshakes of the RX packer.
interface hyperbus_rx_packer_if
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumPhys      = 2,
  parameter int unsigned AxiDataWidth = 64
);

  localparam int unsigned PhyWidth = 16 * NumPhys;
  localparam int unsigned Ratio    = AxiDataWidth / PhyWidth;
  localparam int unsigned IdxW     = lane_idx_w(Ratio);

  logic [IdxW-1:0]           cmd_offset_i;
  logic                      cmd_valid_i;
  logic                      cmd_ready_o;
  hyper_rx_t                 rx_i;
  logic                      rx_valid_i;
  logic                      rx_ready_o;
  logic [AxiDataWidth-1:0]   data_o;
  logic [AxiDataWidth/8-1:0] strb_o;
  logic                      last_o;
  logic                      error_o;
  logic                      valid_o;
  logic                      ready_i;

  modport slave (
    input  cmd_offset_i,
    input  cmd_valid_i,
    output cmd_ready_o,
    input  rx_i,
    input  rx_valid_i,
    output rx_ready_o,
    output data_o,
    output strb_o,
    output last_o,
    output error_o,
    output valid_o,
    input  ready_i
  );

  modport master (
    output cmd_offset_i,
    output cmd_valid_i,
    input  cmd_ready_o,
    output rx_i,
    output rx_valid_i,
    input  rx_ready_o,
    input  data_o,
    input  strb_o,
    input  last_o,
    input  error_o,
    input  valid_o,
    output ready_i
  );

endinterface

// File: rtl/hyperbus_rx_lane_cnt.sv
// Lane counter for the RX packer: load, increment with wrap, clear,
// and a terminal-count flag on the last lane.
module hyperbus_rx_lane_cnt #(
  parameter int unsigned Ratio = 2,
  parameter int unsigned IdxW  = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load,
  input  logic [IdxW-1:0] load_val,
  input  logic            incr,
  input  logic            clr,
  output logic [IdxW-1:0] idx,
  output logic            tc
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(Ratio - 1);

  logic [IdxW-1:0] idx_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q <= '0;
    end else if (load) begin
      idx_q <= (Ratio > 1) ? load_val : '0;
    end else if (clr || (incr && tc)) begin
      idx_q <= '0;
    end else if (incr) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  assign idx = idx_q;
  assign tc  = (idx_q == LastIdx);

endmodule

// File: rtl/hyperbus_rx_packer.sv
// Packs PHY RX words into AXI-width words with byte strobes and merged errors.
// HYPERBUS_RX_PACKER_ZERO_FILL_EN: lanes with strb=0 read as zero on data_o.
module hyperbus_rx_packer
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumPhys      = 2,
  parameter int unsigned AxiDataWidth = 64
) (
  input logic                 clk_i,
  input logic                 rst_i,
  hyperbus_rx_packer_if.slave bus
);

  localparam int unsigned PhyWidth = 16 * NumPhys;
  localparam int unsigned Ratio    = AxiDataWidth / PhyWidth;
  localparam int unsigned IdxW     = lane_idx_w(Ratio);
  localparam int unsigned StrbW    = AxiDataWidth / 8;
  localparam int unsigned LaneB    = PhyWidth / 8;

  if (NumPhys != HyperNumPhys) begin : g_bad_phys
    $error("NumPhys must match hyper_rx_t width");
  end

  if (Ratio == 0 || AxiDataWidth != Ratio * PhyWidth
      || (Ratio & (Ratio - 1)) != 0) begin : g_bad_ratio
    $error("AxiDataWidth/PhyWidth must be a power of two");
  end

  rx_pack_state_e state_q, state_d;

  logic [IdxW-1:0]         lane;
  logic                    lane_tc;
  logic                    cmd_ready;
  logic                    rx_ready;
  logic                    cmd_hs;
  logic                    rx_hs;
  logic                    done;
  logic                    stall;
  logic [AxiDataWidth-1:0] acc_data_q;
  logic [StrbW-1:0]        acc_strb_q;
  logic                    acc_err_q;
  logic [AxiDataWidth-1:0] merge_data;
  logic [StrbW-1:0]        merge_strb;
  logic                    merge_err;
  logic [AxiDataWidth-1:0] data_q;
  logic [StrbW-1:0]        strb_q;
  logic                    last_q;
  logic                    err_q;
  logic                    valid_q;

  // A beat completes on the last lane or on burst end; it may only be
  // taken when the output register is free or draining this cycle.
  assign done  = lane_tc | bus.rx_i.last;
  assign stall = valid_q & ~bus.ready_i & done;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rx_ready  = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid_i) state_d = PACK;
      end
      (state_q == PACK): begin
        rx_ready = ~stall;
        if (bus.rx_valid_i && rx_ready && bus.rx_i.last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_hs = bus.cmd_valid_i & cmd_ready;
  assign rx_hs  = bus.rx_valid_i & rx_ready;

  hyperbus_rx_lane_cnt #(
    .Ratio(Ratio),
    .IdxW (IdxW)
  ) u_lane_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load    (cmd_hs),
    .load_val(bus.cmd_offset_i),
    .incr    (rx_hs),
    .clr     (rx_hs & bus.rx_i.last),
    .idx     (lane),
    .tc      (lane_tc)
  );

  always_comb begin
    merge_data = acc_data_q;
    merge_strb = acc_strb_q;
    merge_data[lane*PhyWidth +: PhyWidth] = bus.rx_i.data;
    merge_strb[lane*LaneB +: LaneB] = '1;
    merge_err = acc_err_q | bus.rx_i.error;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_data_q <= '0;
      acc_strb_q <= '0;
      acc_err_q  <= 1'b0;
      data_q     <= '0;
      strb_q     <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      if (cmd_hs) begin
        acc_strb_q <= '0;
        acc_err_q  <= 1'b0;
      end
      if (rx_hs && !done) begin
        acc_data_q <= merge_data;
        acc_strb_q <= merge_strb;
        acc_err_q  <= merge_err;
      end
      if (rx_hs && done) begin
        data_q     <= merge_data;
        strb_q     <= merge_strb;
        err_q      <= merge_err;
        last_q     <= bus.rx_i.last;
        valid_q    <= 1'b1;
        acc_strb_q <= '0;
        acc_err_q  <= 1'b0;
      end else if (bus.ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef HYPERBUS_RX_PACKER_ZERO_FILL_EN
  logic [AxiDataWidth-1:0] fill_mask;

  always_comb begin
    fill_mask = '0;
    for (int b = 0; b < StrbW; b++) begin
      fill_mask[b*8 +: 8] = {8{strb_q[b]}};
    end
  end

  assign bus.data_o = data_q & fill_mask;
`else
  assign bus.data_o = data_q;
`endif

  assign bus.cmd_ready_o = cmd_ready;
  assign bus.rx_ready_o  = rx_ready;
  assign bus.strb_o      = strb_q;
  assign bus.last_o      = last_q;
  assign bus.error_o     = err_q;
  assign bus.valid_o     = valid_q;

endmodule
